// File: rtl/abm_pkg.sv
// rtl/abm_pkg.sv - shared types and helpers for the ABM clear arbiter
// Purpose: FSM state encoding, bank-mask bit positions and address-width
//          derivation shared by the ABM write-side controller files.
// Ports:   none (package).
package abm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } abm_state_e;

  localparam int BANK0 = 0;
  localparam int BANK1 = 1;

  // Word-address width for a RAM of dd words; a 1-deep RAM still needs a bit.
  function automatic int calc_aw(input int dd);
    return (dd > 1) ? $clog2(dd) : 1;
  endfunction

endpackage

// File: rtl/abm_clear_arbiter_if.sv
// rtl/abm_clear_arbiter_if.sv - bundle of clear, write-request and RAM write signals
// Purpose: groups the clear control, external write handshake and shared RAM
//          write port of the ABM clear arbiter.
// Ports:   clear_start/clear_mask/clear_busy/clear_done - clear control
//          wr_valid/wr_ready/wr_addr/wr_data/wr_bank    - external writer
//          ram_we/ram_waddr/ram_wdata                   - RAM bank write port
//          modport slave = arbiter side, master = producer/RAM side.
interface abm_clear_arbiter_if import abm_pkg::*; #(
  parameter int DW = 512,
  parameter int DD = 16384
) ();
  localparam int AW = calc_aw(DD);

  logic          clear_start;
  logic [1:0]    clear_mask;
  logic          clear_busy;
  logic          clear_done;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_bank;
  logic [1:0]    ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  modport slave (
    input  clear_start, clear_mask, wr_valid, wr_addr, wr_data, wr_bank,
    output clear_busy, clear_done, wr_ready, ram_we, ram_waddr, ram_wdata
  );

  modport master (
    output clear_start, clear_mask, wr_valid, wr_addr, wr_data, wr_bank,
    input  clear_busy, clear_done, wr_ready, ram_we, ram_waddr, ram_wdata
  );

endinterface

// File: rtl/abm_rr_arb2.sv
// rtl/abm_rr_arb2.sv - two-requester round-robin arbiter
// Purpose: grants one of two requesters per cycle; under contention the
//          grant alternates based on a registered last-grant bit.
// Ports:   clk, reset (async active-high)
//          restart - forces requester 0 to win the next contended grant
//          req[1:0] - request vector (0 = writer, 1 = clear engine)
//          gnt[1:0] - one-hot grant, combinational from req and last-grant
module abm_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // last_q = 1 when requester 0 won the most recent grant.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b10 : 2'b01;
    end

    last_d = last_q;
    if (gnt[0]) begin
      last_d = 1'b1;
    end else if (gnt[1]) begin
      last_d = 1'b0;
    end
    // A new sweep always opens with the writer favoured.
    if (restart) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/abm_clear_arbiter.sv
// rtl/abm_clear_arbiter.sv - write-side controller sharing the ABM RAM write port
// Purpose: arbitrates the single RAM write port between an external writer
//          and a clear engine that zero-fills the masked banks, with one
//          registered output stage towards the RAM banks.
// Ports:   clk   - sole clock, rising edge
//          reset - asynchronous active-high reset
//          bus   - abm_clear_arbiter_if.slave (clear control, writer, RAM port)
module abm_clear_arbiter import abm_pkg::*; #(
  parameter int DW = 512,
  parameter int DD = 16384
) (
  input  logic                clk,
  input  logic                reset,
  abm_clear_arbiter_if.slave  bus
);

  localparam int AW = calc_aw(DD);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DD - 1);

  abm_state_e    state_q, state_d;
  logic [1:0]    mask_q, mask_d;
  logic [AW-1:0] clear_addr_q, clear_addr_d;
  logic [1:0]    we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic       restart;
  logic       clr_req;
  logic [1:0] gnt;

  // An empty mask still passes through CLEAR for one cycle so that the
  // done pulse lands two cycles after the start request.
  assign clr_req = (state_q == ST_CLEAR) && (mask_q != 2'b00);
  assign restart = (state_q == ST_IDLE) && bus.clear_start;

  abm_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .req     ({clr_req, bus.wr_valid}),
    .gnt     (gnt)
  );

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    clear_addr_d = clear_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear_start) begin
          mask_d       = bus.clear_mask;
          clear_addr_d = '0;
          state_d      = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (mask_q == 2'b00) begin
          state_d = ST_DONE;
        end else if (gnt[1]) begin
          // Hold at the last address instead of wrapping.
          if (clear_addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            clear_addr_d = clear_addr_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    we_d    = 2'b00;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gnt[1]) begin
      we_d    = mask_q;
      waddr_d = clear_addr_q;
      wdata_d = '0;
    end else if (gnt[0]) begin
      // A zero bank mask is accepted but produces no enables.
      we_d    = bus.wr_bank;
      waddr_d = bus.wr_addr;
      wdata_d = bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mask_q       <= 2'b00;
      clear_addr_q <= '0;
      we_q         <= 2'b00;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      clear_addr_q <= clear_addr_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  // wr_ready is masked by reset so no beat is acknowledged while held.
  assign bus.wr_ready   = bus.wr_valid & gnt[0] & ~reset;
  assign bus.clear_busy = (state_q != ST_IDLE);
  assign bus.clear_done = (state_q == ST_DONE);
  assign bus.ram_we     = we_q;
  assign bus.ram_waddr  = waddr_q;
  assign bus.ram_wdata  = wdata_q;

endmodule

// File: tb/tb_abm_clear_arbiter.sv
// tb/tb_abm_clear_arbiter.sv - scoreboard bench for abm_clear_arbiter
module tb_abm_clear_arbiter;

  localparam int DW = 64;
  localparam int DD = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic [1:0]    we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  abm_clear_arbiter_if #(.DW(DW), .DD(DD)) bus ();

  abm_clear_arbiter #(.DW(DW), .DD(DD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   bare_done = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops one expectation per RAM write; a done pulse without a write must
  // have been announced through bare_done.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ram_we != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(bus.ram_we), 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("ram_we", 64'(bus.ram_we), 64'(e.we));
          chk("ram_waddr", 64'(bus.ram_waddr), 64'(e.addr));
          chk("ram_wdata", bus.ram_wdata, e.data);
          chk("done_with_write", 64'(bus.clear_done), 64'(e.done));
        end
      end else if (bus.clear_done) begin
        chk("bare_done_expected", 64'(bare_done > 0), 64'h1);
        if (bare_done > 0) bare_done--;
      end
    end
  endtask

  task automatic push_sweep(input logic [1:0] m);
    for (int i = 0; i < DD; i++) begin
      exp_q.push_back('{we: m, addr: AW'(i), data: '0, done: (i == DD - 1)});
    end
  endtask

  task automatic run_sweep(input logic [1:0] m, input bit poke);
    int busy_n;
    push_sweep(m);
    bus.clear_start = 1'b1;
    bus.clear_mask  = m;
    step();
    bus.clear_start = 1'b0;
    bus.clear_mask  = 2'b00;
    chk("busy_rise", 64'(bus.clear_busy), 64'h1);
    busy_n = 0;
    for (int c = 1; c < 200; c++) begin
      if (!bus.clear_busy) break;
      busy_n++;
      if (poke && c == 5) begin
        bus.clear_start = 1'b1;
        bus.clear_mask  = 2'b01;
      end
      step();
      bus.clear_start = 1'b0;
      bus.clear_mask  = 2'b00;
    end
    chk("busy_cycles", 64'(busy_n), 64'(DD + 1));
  endtask

  initial begin
    reset           = 1'b1;
    bus.clear_start = 1'b0;
    bus.clear_mask  = 2'b00;
    bus.wr_valid    = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.wr_bank     = 2'b00;
    fork
      monitor();
    join_none
    step();
    step();
    chk("rst_busy", 64'(bus.clear_busy), 64'h0);
    chk("rst_done", 64'(bus.clear_done), 64'h0);
    chk("rst_ready", 64'(bus.wr_ready), 64'h0);
    chk("rst_we", 64'(bus.ram_we), 64'h0);
    chk("rst_waddr", 64'(bus.ram_waddr), 64'h0);
    chk("rst_wdata", bus.ram_wdata, 64'h0);
    reset = 1'b0;
    step();

    // Writer only, then a beat with an empty bank mask.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(5);
    bus.wr_data  = 64'hA5A5_A5A5_A5A5_A5A5;
    bus.wr_bank  = 2'b01;
    exp_q.push_back('{we: 2'b01, addr: AW'(5), data: 64'hA5A5_A5A5_A5A5_A5A5, done: 1'b0});
    #2 chk("wr_only_ready", 64'(bus.wr_ready), 64'h1);
    step();
    bus.wr_addr = AW'(7);
    bus.wr_bank = 2'b00;
    #2 chk("bank0_ready", 64'(bus.wr_ready), 64'h1);
    step();
    bus.wr_valid = 1'b0;
    step();
    step();

    // Full sweep of both banks, with an ignored restart mid-sweep.
    run_sweep(2'b11, 1'b1);
    step();

    // Contended sweep on ram0 against a writer targeting ram1.
    bus.clear_start = 1'b1;
    bus.clear_mask  = 2'b01;
    step();
    bus.clear_start = 1'b0;
    bus.clear_mask  = 2'b00;
    for (int c = 1; c <= 2 * DD; c++) begin
      bus.wr_valid = 1'b1;
      bus.wr_bank  = 2'b10;
      bus.wr_addr  = AW'(c);
      bus.wr_data  = 64'hBEEF_0000_0000_0000 | 64'(c);
      #2 chk("cont_ready", 64'(bus.wr_ready), 64'(c % 2));
      if (c % 2 == 1) begin
        exp_q.push_back('{we: 2'b10, addr: AW'(c), data: 64'hBEEF_0000_0000_0000 | 64'(c), done: 1'b0});
      end else begin
        exp_q.push_back('{we: 2'b01, addr: AW'(c / 2 - 1), data: '0, done: (c == 2 * DD)});
      end
      step();
    end
    bus.wr_valid = 1'b0;
    chk("cont_busy_done", 64'(bus.clear_busy), 64'h1);
    step();
    chk("cont_busy_fall", 64'(bus.clear_busy), 64'h0);
    step();

    // Empty mask: done two cycles after start, no writes.
    bare_done++;
    bus.clear_start = 1'b1;
    bus.clear_mask  = 2'b00;
    step();
    bus.clear_start = 1'b0;
    chk("m0_done_c1", 64'(bus.clear_done), 64'h0);
    step();
    chk("m0_done_c2", 64'(bus.clear_done), 64'h1);
    step();
    chk("m0_busy_c3", 64'(bus.clear_busy), 64'h0);
    step();

    // Reset in the middle of a sweep.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{we: 2'b11, addr: AW'(i), data: '0, done: 1'b0});
    end
    bus.clear_start = 1'b1;
    bus.clear_mask  = 2'b11;
    step();
    bus.clear_start = 1'b0;
    bus.clear_mask  = 2'b00;
    for (int i = 0; i < 4; i++) step();
    reset        = 1'b1;
    bus.wr_valid = 1'b1;
    #1;
    chk("mid_rst_we", 64'(bus.ram_we), 64'h0);
    chk("mid_rst_busy", 64'(bus.clear_busy), 64'h0);
    chk("mid_rst_done", 64'(bus.clear_done), 64'h0);
    chk("mid_rst_ready", 64'(bus.wr_ready), 64'h0);
    chk("mid_rst_waddr", 64'(bus.ram_waddr), 64'h0);
    step();
    step();
    reset        = 1'b0;
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("post_rst_idle", 64'(bus.clear_busy), 64'h0);
    run_sweep(2'b11, 1'b0);

    step();
    step();
    step();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    chk("bare_done_left", 64'(bare_done), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
